hpdcache_mshr_ack_sched: RTL and testbench
==========================================

# hpdcache_mshr_ack_sched

Scheduler for the MSHR's single memory port. It takes refill-completion IDs (set/way) from the refill path and buffers them in a small FIFO. It shares the MSHR port between the miss path (check/alloc) and the refill path (ack), and never drives ack in the same cycle as a miss-path grant. After each ack it holds the port while the MSHR read data is consumed downstream.

## Interface
- MSHR_SET_W, 4, MSHR set index width (≥1)
- MSHR_WAY_W, 2, MSHR way index width (≥1)
- FIFO_DEPTH, 4, pending refill-ID entries (power of two, ≥2)
- STARVE_MAX, 7, max consecutive miss grants while refill IDs are pending (0 = ack always wins)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- refill_valid_i  in  1  refill completion ID offered
- refill_ready_o  out  1  FIFO can accept an ID
- refill_set_i  in  MSHR_SET_W  MSHR set of completed refill
- refill_way_i  in  MSHR_WAY_W  MSHR way of completed refill
- miss_req_i  in  1  miss path requests the MSHR port (check/alloc) this cycle
- miss_gnt_o  out  1  miss path may drive check/alloc this cycle
- mshr_ack_o  out  1  MSHR ack strobe
- mshr_ack_cs_o  out  1  MSHR ack chip select (equals mshr_ack_o)
- mshr_ack_set_o  out  MSHR_SET_W  MSHR ack set
- mshr_ack_way_o  out  MSHR_WAY_W  MSHR ack way
- rsp_valid_o  out  1  MSHR ack read data valid downstream
- rsp_ready_i  in  1  downstream consumes ack read data
- rsp_set_o  out  MSHR_SET_W  set of the entry being presented
- rsp_way_o  out  MSHR_WAY_W  way of the entry being presented
- pending_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

## Operation
- **FIFO**
  - Push when refill_valid_i & refill_ready_o.
  - refill_ready_o = ~full. There is no pop-bypass when full.
  - Pop happens at ack issue.
  - Read/write pointers wrap modulo FIFO_DEPTH. Occupancy is tracked with a separate counter.
- **FSM states: IDLE, RSP.**
- **IDLE**
  - ack_issue = fifo_nonempty & (~miss_req_i | starve_cnt == STARVE_MAX).
  - On ack_issue:
    - mshr_ack_o = mshr_ack_cs_o = 1, with set/way taken from the FIFO head.
    - Pop the FIFO.
    - Latch set/way into rsp_set/rsp_way.
    - Go to RSP.
  - miss_gnt_o = miss_req_i & ~ack_issue.
- **RSP**
  - rsp_valid_o = 1.
  - miss_gnt_o = 0 and mshr_ack_o = 0, so the MSHR read data stays stable.
  - On rsp_ready_i, go to IDLE. No ack is issued in that same cycle.
- **Starvation counter** (width $clog2(STARVE_MAX+1), minimum 1)
  - Increments, saturating at STARVE_MAX, in any IDLE cycle where miss_gnt_o = 1 while the FIFO is non-empty.
  - Clears on ack_issue.
  - Holds otherwise, including when the FIFO is empty.
- mshr_ack_set_o and mshr_ack_way_o always show the FIFO head. Their value is don't-care when mshr_ack_o = 0.
- **Simultaneous push and pop:** allowed. Occupancy is unchanged, and the pushed ID queues behind the remaining entries.
- **Push into an empty FIFO:** the ID becomes eligible for ack the next cycle. There is no same-cycle bypass.

## Timing
- **Reset** (synchronous; applies on the edge where rst_i = 1):
  - state = IDLE, FIFO empty, pointers = 0, starve_cnt = 0, rsp_set/rsp_way = 0.
  - Output values after reset: refill_ready_o = 1, miss_gnt_o = miss_req_i, mshr_ack_o = 0, rsp_valid_o = 0, pending_o = 0.
  - A reset in RSP drops rsp_valid_o on the next cycle.
  - A reset discards all queued IDs.
- **Latency, push to ack:** minimum 1 cycle (push at cycle t, ack at t+1 if the miss path is idle).
- **Latency, ack to rsp_valid_o:** rsp_valid_o rises in cycle ack+1, matching the MSHR's 1-cycle read.
- **Steady-state throughput:** one ack per 2 cycles, when rsp_ready_i is held high.
- **Worst-case ack delay under continuous miss_req_i:** STARVE_MAX grants, then a forced ack.
- **Combinational paths:**
  - miss_gnt_o depends on miss_req_i.
  - refill_ready_o is registered-only, so it has no combinational path from refill_valid_i.

## Test plan
- **Single refill, idle miss path.**
  - Stimulus: push (set=3, way=1) at cycle 0, rsp_ready_i = 1.
  - Required: ack with set=3/way=1 at cycle 1; rsp_valid_o at cycle 2 with rsp_set=3/rsp_way=1; back to IDLE at cycle 3; pending_o goes 1→0 at cycle 1.
- **Starvation.**
  - Stimulus: STARVE_MAX=7, miss_req_i held high, push 1 ID.
  - Required: exactly 7 miss grants, then miss_gnt_o = 0 with mshr_ack_o = 1 in the 8th cycle; the counter returns to 0.
- **FIFO full and wrap-around.**
  - Stimulus: push 4 IDs (0..3) while miss_req_i is held high and STARVE_MAX=7.
  - Required: refill_ready_o = 0 with pending_o = 4; a 5th push is not accepted; then push 6 more IDs as acks drain the FIFO.
  - Acks must come out in exact push order across the pointer wrap.
- **Backpressure in RSP.**
  - Stimulus: rsp_ready_i low for 5 cycles after an ack, miss_req_i high.
  - Required: rsp_valid_o high for 5 cycles with stable set/way; miss_gnt_o = 0 and no ack throughout; IDLE after the cycle in which rsp_ready_i rises.
- **Reset mid-operation.**
  - Stimulus: 3 IDs queued, state RSP, rst_i pulsed for 1 cycle.
  - Required: the next cycle shows rsp_valid_o = 0, pending_o = 0, refill_ready_o = 1; no ack for the flushed IDs.
- **Invariant over 10k random cycles:** mshr_ack_o & miss_gnt_o is never 1; rsp_valid_o never asserts without an ack in the previous cycle.

Source files
------------

// File: rtl/hpdcache_mshr_ack_sched.sv
// Arbitrates the MSHR's single port between miss-path check/alloc and refill acks.
// Refill IDs are queued in a small FIFO; each ack holds the port until its read data is consumed.
module hpdcache_mshr_ack_sched #(
  parameter int unsigned MSHR_SET_W = 4,
  parameter int unsigned MSHR_WAY_W = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STARVE_MAX = 7
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          refill_valid_i,
  output logic                          refill_ready_o,
  input  logic [MSHR_SET_W-1:0]         refill_set_i,
  input  logic [MSHR_WAY_W-1:0]         refill_way_i,
  input  logic                          miss_req_i,
  output logic                          miss_gnt_o,
  output logic                          mshr_ack_o,
  output logic                          mshr_ack_cs_o,
  output logic [MSHR_SET_W-1:0]         mshr_ack_set_o,
  output logic [MSHR_WAY_W-1:0]         mshr_ack_way_o,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [MSHR_SET_W-1:0]         rsp_set_o,
  output logic [MSHR_WAY_W-1:0]         rsp_way_o,
  output logic [$clog2(FIFO_DEPTH):0]   pending_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SC_W  = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam int unsigned ID_W  = MSHR_SET_W + MSHR_WAY_W;
  localparam logic [SC_W-1:0]  STARVE_LIM = SC_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);

  typedef enum logic {ST_IDLE, ST_RSP} state_t;

  state_t                  state_q, state_d;
  logic [ID_W-1:0]         mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [SC_W-1:0]         starve_q;
  logic [MSHR_SET_W-1:0]   rsp_set_q;
  logic [MSHR_WAY_W-1:0]   rsp_way_q;

  logic                    full, nonempty, push, ack_issue, gnt;
  logic [ID_W-1:0]         head;

  assign full     = (cnt_q == DEPTH_C);
  assign nonempty = (cnt_q != '0);
  assign push     = refill_valid_i & ~full;
  assign head     = mem_q[rd_ptr_q];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    ack_issue = 1'b0;
    gnt       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ack_issue = nonempty & (~miss_req_i | (starve_q == STARVE_LIM));
        gnt       = miss_req_i & ~ack_issue;
        if (ack_issue) state_d = ST_RSP;
      end
      ST_RSP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      starve_q  <= '0;
      rsp_set_q <= '0;
      rsp_way_q <= '0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (ack_issue) begin
        rd_ptr_q  <= rd_ptr_q + PTR_W'(1);
        rsp_set_q <= head[ID_W-1:MSHR_WAY_W];
        rsp_way_q <= head[MSHR_WAY_W-1:0];
      end
      case ({push, ack_issue})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
      // Starvation only accrues while an ID is actually waiting behind the miss path.
      if (ack_issue)
        starve_q <= '0;
      else if (gnt && nonempty && (starve_q != STARVE_LIM))
        starve_q <= starve_q + SC_W'(1);
    end
  end

  // NOTE: storage is not reset; an entry is only read once the occupancy counter covers it.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {refill_set_i, refill_way_i};
  end

  assign refill_ready_o = ~full;
  assign miss_gnt_o     = gnt;
  assign mshr_ack_o     = ack_issue;
  assign mshr_ack_cs_o  = ack_issue;
  assign mshr_ack_set_o = head[ID_W-1:MSHR_WAY_W];
  assign mshr_ack_way_o = head[MSHR_WAY_W-1:0];
  assign rsp_valid_o    = (state_q == ST_RSP);
  assign rsp_set_o      = rsp_set_q;
  assign rsp_way_o      = rsp_way_q;
  assign pending_o      = cnt_q;

endmodule

// File: tb/tb_hpdcache_mshr_ack_sched.sv
// Self-checking bench: directed vector table, corner-case sequences and random traffic
// compared every cycle against a queue-based reference model.
module tb_hpdcache_mshr_ack_sched;

  localparam int SET_W  = 4;
  localparam int WAY_W  = 2;
  localparam int DEPTH  = 4;
  localparam int SMAX   = 7;
  localparam int PEND_W = $clog2(DEPTH) + 1;

  logic                 clk_i = 1'b0;
  logic                 rst_i = 1'b1;
  logic                 refill_valid_i = 1'b0;
  logic                 refill_ready_o;
  logic [SET_W-1:0]     refill_set_i = '0;
  logic [WAY_W-1:0]     refill_way_i = '0;
  logic                 miss_req_i = 1'b0;
  logic                 miss_gnt_o;
  logic                 mshr_ack_o;
  logic                 mshr_ack_cs_o;
  logic [SET_W-1:0]     mshr_ack_set_o;
  logic [WAY_W-1:0]     mshr_ack_way_o;
  logic                 rsp_valid_o;
  logic                 rsp_ready_i = 1'b1;
  logic [SET_W-1:0]     rsp_set_o;
  logic [WAY_W-1:0]     rsp_way_o;
  logic [PEND_W-1:0]    pending_o;

  hpdcache_mshr_ack_sched #(
    .MSHR_SET_W(SET_W), .MSHR_WAY_W(WAY_W), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .refill_valid_i(refill_valid_i), .refill_ready_o(refill_ready_o),
    .refill_set_i(refill_set_i), .refill_way_i(refill_way_i),
    .miss_req_i(miss_req_i), .miss_gnt_o(miss_gnt_o),
    .mshr_ack_o(mshr_ack_o), .mshr_ack_cs_o(mshr_ack_cs_o),
    .mshr_ack_set_o(mshr_ack_set_o), .mshr_ack_way_o(mshr_ack_way_o),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_set_o(rsp_set_o), .rsp_way_o(rsp_way_o),
    .pending_o(pending_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of packed {set,way} IDs, a response-busy flag, a starvation count.
  int unsigned q[$];
  bit          m_rsp = 0;
  int          m_starve = 0;
  int unsigned m_rsp_id = 0;
  bit          acc;
  logic        prev_ack = 1'b0;
  logic        prev_rv  = 1'b0;

  // One clock cycle: drive inputs after the falling edge, compare mid-cycle, advance the model.
  task automatic drive(input bit rst, input bit valid, input int set, input int way,
                       input bit miss, input bit rrdy, input bit chk);
    bit          ne, full, e_ack, e_gnt;
    int unsigned id;
    @(negedge clk_i);
    rst_i          = rst;
    refill_valid_i = valid;
    refill_set_i   = SET_W'(set);
    refill_way_i   = WAY_W'(way);
    miss_req_i     = miss;
    rsp_ready_i    = rrdy;
    #1;
    id    = (int'(set[SET_W-1:0]) << WAY_W) | int'(way[WAY_W-1:0]);
    ne    = (q.size() != 0);
    full  = (q.size() == DEPTH);
    e_ack = !m_rsp && ne && (!miss || m_starve == SMAX);
    e_gnt = !m_rsp && miss && !e_ack;
    acc   = valid && !full;
    if (chk) begin
      check("m_ready", refill_ready_o, !full);
      check("m_gnt", miss_gnt_o, e_gnt);
      check("m_ack", mshr_ack_o, e_ack);
      check("m_ack_cs", mshr_ack_cs_o, e_ack);
      check("m_pending", pending_o, q.size());
      check("m_rsp_valid", rsp_valid_o, m_rsp);
      check("inv_ack_gnt_excl", mshr_ack_o & miss_gnt_o, 0);
      if (e_ack) check("m_ack_id", {mshr_ack_set_o, mshr_ack_way_o}, q[0]);
      if (m_rsp) check("m_rsp_id", {rsp_set_o, rsp_way_o}, m_rsp_id);
      if (rsp_valid_o === 1'b1 && prev_rv !== 1'b1)
        check("inv_rsp_after_ack", prev_ack, 1);
    end
    prev_ack = mshr_ack_o;
    prev_rv  = rsp_valid_o;
    if (rst) begin
      q.delete();
      m_rsp = 0;
      m_starve = 0;
      m_rsp_id = 0;
      prev_ack = 1'b0;
      prev_rv  = 1'b0;
    end else begin
      if (e_ack) begin
        m_rsp_id = q.pop_front();
        m_rsp = 1;
        m_starve = 0;
      end else if (m_rsp && rrdy) begin
        m_rsp = 0;
      end else if (e_gnt && ne && m_starve < SMAX) begin
        m_starve++;
      end
      if (acc) q.push_back(id);
    end
  endtask

  typedef struct {
    bit valid; int set; int way; bit miss; bit rrdy;
    bit e_ready; bit e_gnt; bit e_ack; int e_ack_set; int e_ack_way;
    bit e_rv; int e_rsp_set; int e_rsp_way; int e_pend;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int grants;
    bit got;
    int next_push, next_ack;

    // Single refill with idle miss path, then miss grant with empty FIFO.
    vecs[0] = '{1, 3, 1, 0, 1,  1, 0, 0, 0, 0,  0, 0, 0, 0};
    vecs[1] = '{0, 0, 0, 0, 1,  1, 0, 1, 3, 1,  0, 0, 0, 1};
    vecs[2] = '{0, 0, 0, 1, 1,  1, 0, 0, 0, 0,  1, 3, 1, 0};
    vecs[3] = '{0, 0, 0, 1, 1,  1, 1, 0, 0, 0,  0, 0, 0, 0};
    vecs[4] = '{0, 0, 0, 0, 1,  1, 0, 0, 0, 0,  0, 0, 0, 0};

    drive(1, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 1, 0);

    // Reset state
    drive(0, 0, 0, 0, 1, 1, 1);
    check("rst_ready", refill_ready_o, 1);
    check("rst_gnt_follows_req", miss_gnt_o, 1);
    check("rst_ack", mshr_ack_o, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_pending", pending_o, 0);

    foreach (vecs[i]) begin
      drive(0, vecs[i].valid, vecs[i].set, vecs[i].way, vecs[i].miss, vecs[i].rrdy, 1);
      check("vec_ready", refill_ready_o, vecs[i].e_ready);
      check("vec_gnt", miss_gnt_o, vecs[i].e_gnt);
      check("vec_ack", mshr_ack_o, vecs[i].e_ack);
      check("vec_rsp_valid", rsp_valid_o, vecs[i].e_rv);
      check("vec_pending", pending_o, vecs[i].e_pend);
      if (vecs[i].e_ack) begin
        check("vec_ack_set", mshr_ack_set_o, vecs[i].e_ack_set);
        check("vec_ack_way", mshr_ack_way_o, vecs[i].e_ack_way);
      end
      if (vecs[i].e_rv) begin
        check("vec_rsp_set", rsp_set_o, vecs[i].e_rsp_set);
        check("vec_rsp_way", rsp_way_o, vecs[i].e_rsp_way);
      end
    end

    // Starvation: two rounds show both the limit and the counter clearing after an ack.
    for (int r = 0; r < 2; r++) begin
      drive(0, 1, 5 + r, 2, 1, 1, 1);
      grants = 0;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
        drive(0, 0, 0, 0, 1, 1, 1);
        if (mshr_ack_o === 1'b1) got = 1;
        else if (miss_gnt_o === 1'b1) grants++;
      end
      check("starve_grants", grants, SMAX);
      check("starve_forced_ack", got, 1);
      check("starve_gnt_at_ack", miss_gnt_o, 0);
      check("starve_ack_set", mshr_ack_set_o, 5 + r);
      drive(0, 0, 0, 0, 1, 1, 1);
      drive(0, 0, 0, 0, 0, 1, 1);
    end

    // FIFO full and pointer wrap under continuous miss requests.
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 1, i, i % 4, 1, 1, 1);
      check("fill_accept", acc, 1);
    end
    next_push = DEPTH;
    next_ack = 0;
    drive(0, 1, next_push, next_push % 4, 1, 1, 1);
    check("full_ready", refill_ready_o, 0);
    check("full_pending", pending_o, DEPTH);
    check("full_refused", acc, 0);
    for (int c = 0; c < 400 && next_ack < 10; c++) begin
      drive(0, next_push < 10, next_push, next_push % 4, 1, 1, 1);
      if (mshr_ack_o === 1'b1) begin
        check("wrap_order", {mshr_ack_set_o, mshr_ack_way_o}, (next_ack << WAY_W) | (next_ack % 4));
        next_ack++;
      end
      if (acc) next_push++;
    end
    check("wrap_all_acked", next_ack, 10);
    repeat (3) drive(0, 0, 0, 0, 0, 1, 1);

    // Backpressure while holding the read data.
    drive(0, 1, 9, 2, 0, 0, 1);
    drive(0, 1, 10, 3, 0, 0, 1);
    check("bp_ack", mshr_ack_o, 1);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 1, 0, 1);
      check("bp_rsp_valid", rsp_valid_o, 1);
      check("bp_rsp_set", rsp_set_o, 9);
      check("bp_rsp_way", rsp_way_o, 2);
      check("bp_no_gnt", miss_gnt_o, 0);
      check("bp_no_ack", mshr_ack_o, 0);
    end
    drive(0, 0, 0, 0, 1, 1, 1);
    check("bp_release_cycle_valid", rsp_valid_o, 1);
    drive(0, 0, 0, 0, 1, 1, 1);
    check("bp_idle_rsp_valid", rsp_valid_o, 0);
    check("bp_idle_gnt", miss_gnt_o, 1);
    repeat (4) drive(0, 0, 0, 0, 0, 1, 1);

    // Reset while in RSP with three IDs queued.
    drive(0, 1, 1, 0, 0, 0, 1);
    drive(0, 1, 2, 1, 0, 0, 1);
    drive(0, 1, 3, 2, 0, 0, 1);
    drive(0, 1, 4, 3, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 1);
    check("pre_rst_pending", pending_o, 3);
    check("pre_rst_rsp_valid", rsp_valid_o, 1);
    drive(0, 0, 0, 0, 0, 1, 1);
    check("post_rst_rsp_valid", rsp_valid_o, 0);
    check("post_rst_pending", pending_o, 0);
    check("post_rst_ready", refill_ready_o, 1);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 0, 1, 1);
      check("flush_no_ack", mshr_ack_o, 0);
    end

    // Random traffic against the model.
    for (int i = 0; i < 10000; i++) begin
      drive($urandom_range(0, 499) == 0, $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
            $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 7, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
